// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_skew_feeder_pkg: shared lane tags and feeder FSM states for the matmul systolic array
package systolic_skew_feeder_pkg;
  // S_IDLE encodes as zero so cleared skew registers read back as idle lanes
  typedef enum logic [1:0] {S_IDLE = 2'd0, S0 = 2'd1, S1 = 2'd2} systolic_state_t;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} feeder_state_t;
  localparam int STATE_W = $bits(systolic_state_t);
endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift chain of W-bit words, async-cleared to zero
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] r_q, r_d;
  always_comb begin
    r_d = '0;
    r_d[0] = d;
    for (int i = 1; i < DEPTH; i++) r_d[i] = r_q[i-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else r_q <= r_d;
  end
  assign q = r_q[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: diagonally skews operand lanes with per-lane accumulator tags and batch drain.
// Optional FEEDER_PROTO_CHECK_EN adds a sticky out_err protocol-violation flag.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N = 4,
  parameter int IN_DIM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_data,
  input  logic                  in_last,
  output logic [N*DATA_W-1:0]   out_data,
  output logic [N*STATE_W-1:0]  out_state,
  output logic                  out_tile_done,
  output logic                  out_batch_done
`ifdef FEEDER_PROTO_CHECK_EN
  ,
  output logic                  out_err
`endif
);
  localparam int CW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  feeder_state_t state_q, state_d;
  logic [CW-1:0] term_q, term_d;
  logic [DW-1:0] drain_q, drain_d;
  logic in_ready_q, in_ready_d;
  logic batch_done_q, batch_done_d;
  logic xfer, last_term;
  systolic_state_t tag;
  assign xfer = in_valid && in_ready_q;
  assign last_term = term_q == CW'(IN_DIM - 1);
  // Bubbles mid-tile keep S1 so the zero term leaves the running sum intact
  always_comb begin
    term_d = xfer ? (last_term ? '0 : term_q + 1'b1) : term_q;
    tag = xfer ? ((term_q == '0) ? S0 : S1) : ((term_q != '0) ? S1 : S_IDLE);
  end
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    batch_done_d = 1'b0;
    case (state_q)
      IDLE, FEED: begin
        if (xfer && in_last && last_term) begin
          state_d = DRAIN;
          drain_d = DW'(N - 1);
        end else if (xfer) begin
          state_d = FEED;
        end
      end
      DRAIN: begin
        if (drain_q <= DW'(1)) begin
          state_d = IDLE;
          batch_done_d = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d != DRAIN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      term_q <= '0;
      drain_q <= '0;
      in_ready_q <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q <= term_d;
      drain_q <= drain_d;
      in_ready_q <= in_ready_d;
      batch_done_q <= batch_done_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_batch_done = batch_done_q;
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W+STATE_W-1:0] q;
    skew_delay_line #(.DEPTH(i + 1), .W(DATA_W + STATE_W)) u_dl (
      .clk(clk),
      .rst(rst),
      .d({tag, xfer ? in_data[i*DATA_W +: DATA_W] : DATA_W'(0)}),
      .q(q)
    );
    assign out_data[i*DATA_W +: DATA_W] = q[DATA_W-1:0];
    assign out_state[i*STATE_W +: STATE_W] = q[DATA_W +: STATE_W];
  end
  skew_delay_line #(.DEPTH(N), .W(1)) u_tile_done (
    .clk(clk),
    .rst(rst),
    .d(xfer && last_term),
    .q(out_tile_done)
  );
`ifdef FEEDER_PROTO_CHECK_EN
  localparam int IW = $clog2(IN_DIM + 2);
  logic err_q, err_d;
  logic [IW-1:0] gap_q, gap_d;
  logic stall;
  assign stall = !in_valid && term_q != '0;
  // gap_q counts prior stalled cycles; the (IN_DIM+1)th consecutive stall flags
  always_comb begin
    gap_d = stall ? ((gap_q == IW'(IN_DIM)) ? gap_q : gap_q + 1'b1) : '0;
    err_d = err_q || (xfer && in_last && !last_term) || (stall && gap_q == IW'(IN_DIM));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      gap_q <= '0;
    end else begin
      err_q <= err_d;
      gap_q <= gap_d;
    end
  end
  assign out_err = err_q;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: randomized and directed checks of the skew feeder against a cycle-history model
module tb_systolic_skew_feeder;
  import systolic_skew_feeder_pkg::*;
  localparam int DATA_W = 32, N = 4, IN_DIM = 3, SW = 2, VW = N * DATA_W;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic in_ready, out_tile_done, out_batch_done;
  logic [VW-1:0] out_data;
  logic [N*SW-1:0] out_state;
`ifdef FEEDER_PROTO_CHECK_EN
  logic out_err;
`endif
  systolic_skew_feeder #(.DATA_W(DATA_W), .N(N), .IN_DIM(IN_DIM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_data(out_data), .out_state(out_state),
    .out_tile_done(out_tile_done), .out_batch_done(out_batch_done)
`ifdef FEEDER_PROTO_CHECK_EN
    , .out_err(out_err)
`endif
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  int k, m_term, last_t, drain_end;
  logic [VW-1:0] h_data [1024];
  logic [1:0] h_tag [1024];
  bit h_tend [1024];
  // Model: what entered the array at each cycle; lane i shows entry k-1-i
  function automatic bit m_ready();
    return !(k > last_t && k <= drain_end);
  endfunction
  function automatic bit m_bdone();
    return k == drain_end + 1;
  endfunction
  function automatic logic [VW-1:0] exp_data();
    logic [VW-1:0] r = '0;
    for (int i = 0; i < N; i++) if (k - 1 - i >= 0) r[i*DATA_W +: DATA_W] = h_data[k-1-i][i*DATA_W +: DATA_W];
    return r;
  endfunction
  function automatic logic [N*SW-1:0] exp_state();
    logic [N*SW-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*SW +: SW] = (k - 1 - i >= 0) ? h_tag[k-1-i] : S_IDLE;
    return r;
  endfunction
  function automatic bit exp_tile();
    return (k - N >= 0) ? h_tend[k-N] : 1'b0;
  endfunction
  function automatic logic [VW-1:0] vec(input int base);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = DATA_W'(base + i);
    return r;
  endfunction
  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = $urandom;
    return r;
  endfunction
  task automatic model_reset();
    k = 0; m_term = 0; last_t = -100; drain_end = -100;
  endtask
  task automatic step(input bit v, input logic [VW-1:0] d, input bit last);
    bit x;
    in_valid = v; in_data = d; in_last = last;
    x = v && m_ready();
    h_data[k] = x ? d : '0;
    h_tag[k] = x ? ((m_term == 0) ? S0 : S1) : ((m_term != 0) ? S1 : S_IDLE);
    h_tend[k] = x && m_term == IN_DIM - 1;
    if (x && last && m_term == IN_DIM - 1) begin
      last_t = k;
      drain_end = k + ((N > 1) ? N - 1 : 1);
    end
    if (x) m_term = (m_term + 1) % IN_DIM;
    @(posedge clk); #1;
    k++;
  endtask
  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    in_valid = 1'b1; in_data = vec(77);
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (out_data !== '0) begin errs++; $display("FAIL reset_data got=%h exp=0", out_data); end
    if (out_state !== {N{S_IDLE}}) begin errs++; $display("FAIL reset_state got=%h exp=%h", out_state, {N{S_IDLE}}); end
    if (out_tile_done !== 1'b0) begin errs++; $display("FAIL reset_tile got=%b exp=0", out_tile_done); end
    if (out_batch_done !== 1'b0) begin errs++; $display("FAIL reset_batch got=%b exp=0", out_batch_done); end
    if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks += 2;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    if (out_state !== {N{S_IDLE}}) begin errs++; $display("FAIL reset_release_state got=%h exp=%h", out_state, {N{S_IDLE}}); end
  endtask
  task automatic test_single_tile();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      step(c < 3, (c < 3) ? vec(1 + 4 * c) : '0, c == 2);
      checks += 5;
      if (out_data !== exp_data()) begin errs++; $display("FAIL tile_data k=%0d got=%h exp=%h", k, out_data, exp_data()); end
      if (out_state !== exp_state()) begin errs++; $display("FAIL tile_state k=%0d got=%h exp=%h", k, out_state, exp_state()); end
      if (out_tile_done !== exp_tile()) begin errs++; $display("FAIL tile_done k=%0d got=%b exp=%b", k, out_tile_done, exp_tile()); end
      if (out_batch_done !== m_bdone()) begin errs++; $display("FAIL tile_batch k=%0d got=%b exp=%b", k, out_batch_done, m_bdone()); end
      if (in_ready !== m_ready()) begin errs++; $display("FAIL tile_ready k=%0d got=%b exp=%b", k, in_ready, m_ready()); end
      if (k == 1) begin
        checks++;
        if (out_data[31:0] !== 32'd1 || out_state[1:0] !== S0) begin errs++; $display("FAIL tile_lane0_first got=%0d/%0d exp=1/%0d", out_data[31:0], out_state[1:0], S0); end
      end
      if (k == 4) begin
        checks++;
        if (out_data[127:96] !== 32'd4 || out_state[7:6] !== S0) begin errs++; $display("FAIL tile_lane3_first got=%0d/%0d exp=4/%0d", out_data[127:96], out_state[7:6], S0); end
      end
      if (k == 6) begin
        checks++;
        if (out_data[127:96] !== 32'd12 || out_tile_done !== 1'b1 || out_batch_done !== 1'b1) begin errs++; $display("FAIL tile_end got=%0d,%b,%b exp=12,1,1", out_data[127:96], out_tile_done, out_batch_done); end
      end
      if (k >= 3 && k <= 5) begin
        checks++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL tile_drain_ready k=%0d got=%b exp=0", k, in_ready); end
      end
    end
  endtask
  task automatic test_bubble();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(c < 4 && c != 1, (c < 4) ? vec(1 + 4 * ((c == 0) ? 0 : c - 1)) : '0, c == 3);
      checks += 5;
      if (out_data !== exp_data()) begin errs++; $display("FAIL bubble_data k=%0d got=%h exp=%h", k, out_data, exp_data()); end
      if (out_state !== exp_state()) begin errs++; $display("FAIL bubble_state k=%0d got=%h exp=%h", k, out_state, exp_state()); end
      if (out_tile_done !== exp_tile()) begin errs++; $display("FAIL bubble_tile k=%0d got=%b exp=%b", k, out_tile_done, exp_tile()); end
      if (out_batch_done !== m_bdone()) begin errs++; $display("FAIL bubble_batch k=%0d got=%b exp=%b", k, out_batch_done, m_bdone()); end
      if (in_ready !== m_ready()) begin errs++; $display("FAIL bubble_ready k=%0d got=%b exp=%b", k, in_ready, m_ready()); end
      if (k == 2) begin
        checks++;
        if (out_data[31:0] !== 32'd0 || out_state[1:0] !== S1) begin errs++; $display("FAIL bubble_lane0 got=%0d/%0d exp=0/%0d", out_data[31:0], out_state[1:0], S1); end
      end
      if (k == 7) begin
        checks++;
        if (out_tile_done !== 1'b1) begin errs++; $display("FAIL bubble_tile7 got=%b exp=1", out_tile_done); end
      end
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(c < 6, (c < 6) ? vec(100 + 4 * c) : '0, c == 5);
      checks += 5;
      if (out_data !== exp_data()) begin errs++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, out_data, exp_data()); end
      if (out_state !== exp_state()) begin errs++; $display("FAIL b2b_state k=%0d got=%h exp=%h", k, out_state, exp_state()); end
      if (out_tile_done !== exp_tile()) begin errs++; $display("FAIL b2b_tile k=%0d got=%b exp=%b", k, out_tile_done, exp_tile()); end
      if (out_batch_done !== m_bdone()) begin errs++; $display("FAIL b2b_batch k=%0d got=%b exp=%b", k, out_batch_done, m_bdone()); end
      if (in_ready !== m_ready()) begin errs++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, in_ready, m_ready()); end
      if (k == 1 || k == 4) begin
        checks++;
        if (out_state[1:0] !== S0) begin errs++; $display("FAIL b2b_restart k=%0d got=%0d exp=%0d", k, out_state[1:0], S0); end
      end
      if (k == 6 || k == 9) begin
        checks++;
        if (out_tile_done !== 1'b1) begin errs++; $display("FAIL b2b_tile_pulse k=%0d got=%b exp=1", k, out_tile_done); end
      end
      if (k <= 5) begin
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_hold k=%0d got=%b exp=1", k, in_ready); end
      end
    end
  endtask
  task automatic test_last_ignored();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(c < 6, (c < 6) ? vec(200 + 4 * c) : '0, c == 1 || c == 5);
      checks += 5;
      if (out_data !== exp_data()) begin errs++; $display("FAIL last_data k=%0d got=%h exp=%h", k, out_data, exp_data()); end
      if (out_state !== exp_state()) begin errs++; $display("FAIL last_state k=%0d got=%h exp=%h", k, out_state, exp_state()); end
      if (out_tile_done !== exp_tile()) begin errs++; $display("FAIL last_tile k=%0d got=%b exp=%b", k, out_tile_done, exp_tile()); end
      if (out_batch_done !== m_bdone()) begin errs++; $display("FAIL last_batch k=%0d got=%b exp=%b", k, out_batch_done, m_bdone()); end
      if (in_ready !== m_ready()) begin errs++; $display("FAIL last_ready k=%0d got=%b exp=%b", k, in_ready, m_ready()); end
      if (k == 3 || k == 4) begin
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL last_ignored_ready k=%0d got=%b exp=1", k, in_ready); end
      end
`ifdef FEEDER_PROTO_CHECK_EN
      checks++;
      if (out_err !== (k >= 2)) begin errs++; $display("FAIL last_err k=%0d got=%b exp=%b", k, out_err, k >= 2); end
`endif
    end
  endtask
  task automatic test_valid_in_drain();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(c < 9, vec(300 + 4 * c), c == 2);
      checks += 5;
      if (out_data !== exp_data()) begin errs++; $display("FAIL drainv_data k=%0d got=%h exp=%h", k, out_data, exp_data()); end
      if (out_state !== exp_state()) begin errs++; $display("FAIL drainv_state k=%0d got=%h exp=%h", k, out_state, exp_state()); end
      if (out_tile_done !== exp_tile()) begin errs++; $display("FAIL drainv_tile k=%0d got=%b exp=%b", k, out_tile_done, exp_tile()); end
      if (out_batch_done !== m_bdone()) begin errs++; $display("FAIL drainv_batch k=%0d got=%b exp=%b", k, out_batch_done, m_bdone()); end
      if (in_ready !== m_ready()) begin errs++; $display("FAIL drainv_ready k=%0d got=%b exp=%b", k, in_ready, m_ready()); end
      if (k == 7) begin
        checks++;
        if (out_data[31:0] !== 32'd324 || out_state[1:0] !== S0) begin errs++; $display("FAIL drainv_restart got=%0d/%0d exp=324/%0d", out_data[31:0], out_state[1:0], S0); end
      end
    end
  endtask
  task automatic test_reset_in_drain();
    do_reset();
    for (int c = 0; c < 4; c++) step(c < 3, vec(400 + 4 * c), c == 2);
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (out_data !== '0) begin errs++; $display("FAIL rdrain_data got=%h exp=0", out_data); end
    if (out_state !== {N{S_IDLE}}) begin errs++; $display("FAIL rdrain_state got=%h exp=%h", out_state, {N{S_IDLE}}); end
    if (out_tile_done !== 1'b0) begin errs++; $display("FAIL rdrain_tile got=%b exp=0", out_tile_done); end
    if (out_batch_done !== 1'b0) begin errs++; $display("FAIL rdrain_batch got=%b exp=0", out_batch_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL rdrain_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, '0, 1'b0);
      checks += 3;
      if (out_batch_done !== 1'b0) begin errs++; $display("FAIL rdrain_no_batch k=%0d got=%b exp=0", k, out_batch_done); end
      if (out_tile_done !== 1'b0) begin errs++; $display("FAIL rdrain_no_tile k=%0d got=%b exp=0", k, out_tile_done); end
      if (out_state !== {N{S_IDLE}}) begin errs++; $display("FAIL rdrain_idle k=%0d got=%h exp=%h", k, out_state, {N{S_IDLE}}); end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      step(($urandom % 4) != 0, rnd_vec(), ($urandom % 3) == 0);
      checks += 5;
      if (out_data !== exp_data()) begin errs++; $display("FAIL rand_data k=%0d got=%h exp=%h", k, out_data, exp_data()); end
      if (out_state !== exp_state()) begin errs++; $display("FAIL rand_state k=%0d got=%h exp=%h", k, out_state, exp_state()); end
      if (out_tile_done !== exp_tile()) begin errs++; $display("FAIL rand_tile k=%0d got=%b exp=%b", k, out_tile_done, exp_tile()); end
      if (out_batch_done !== m_bdone()) begin errs++; $display("FAIL rand_batch k=%0d got=%b exp=%b", k, out_batch_done, m_bdone()); end
      if (in_ready !== m_ready()) begin errs++; $display("FAIL rand_ready k=%0d got=%b exp=%b", k, in_ready, m_ready()); end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_single_tile();
    test_bubble();
    test_back_to_back();
    test_last_ignored();
    test_valid_in_drain();
    test_reset_in_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
